// File: rtl/lsu_mem_stage.sv
// Load/store memory stage: req/ack handshake to memory, lane alignment, load extension, misalign/timeout flags.
// Latency: 1 cycle for non-memory/misaligned ops, ack edge + 1 for memory ops; in_ready low while a request is outstanding.
module lsu_mem_stage #(
    parameter int XLEN        = 32,
    parameter int WORD_ADDR_W = XLEN - $clog2(XLEN / 8),
    parameter int TIMEOUT     = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [XLEN-1:0]        in_result,
    input  logic [XLEN-1:0]        in_wdata,
    input  logic [2:0]             in_funct3,
    input  logic [4:0]             in_rd,
    input  logic                   in_read,
    input  logic                   in_write,
    input  logic                   in_write_reg,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [WORD_ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]        mem_wdata,
    output logic [XLEN/8-1:0]      mem_be,
    input  logic                   mem_ack,
    input  logic [XLEN-1:0]        mem_rdata,
    output logic                   out_valid,
    output logic [4:0]             out_rd,
    output logic [XLEN-1:0]        out_data,
    output logic                   out_write_reg,
    output logic                   misalign_err,
    output logic                   timeout_err
);
    localparam int NB  = XLEN / 8;
    localparam int OFS = $clog2(NB);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] REQ  = 1'b1;

    logic [0:0]      state;
    logic [7:0]      cnt;
    logic [1:0]      op_size;
    logic            op_uns;
    logic [OFS-1:0]  op_off;
    logic            op_wreg;
    logic [4:0]      op_rd;

    logic            accept;
    logic            is_mem;
    logic            misaligned;
    logic [OFS-1:0]  off;
    logic [NB-1:0]   be_mask;
    logic [XLEN-1:0] lane;
    logic [XLEN-1:0] ld_mask;
    logic [XLEN-1:0] ld_data;
    logic            ld_sign;

    assign in_ready = (state == IDLE);
    assign accept   = in_valid && in_ready;
    assign is_mem   = in_read || in_write;
    assign off      = in_result[OFS-1:0];

    // Double-word accesses only exist on a 64-bit datapath; elsewhere they are reported as misaligned.
    always_comb begin
        misaligned = 1'b0;
        be_mask    = '0;
        case (in_funct3[1:0])
            2'b00: begin
                be_mask = NB'(1);
            end
            2'b01: begin
                misaligned = in_result[0];
                be_mask    = NB'(3);
            end
            2'b10: begin
                misaligned = |in_result[1:0];
                be_mask    = NB'(15);
            end
            default: begin
                misaligned = (XLEN != 64) || (|in_result[2:0]);
                be_mask    = '1;
            end
        endcase
    end

    always_comb begin
        lane    = mem_rdata >> {op_off, 3'b000};
        ld_mask = '1;
        ld_sign = lane[XLEN-1];
        case (op_size)
            2'b00: begin
                ld_mask = XLEN'(8'hFF);
                ld_sign = lane[7];
            end
            2'b01: begin
                ld_mask = XLEN'(16'hFFFF);
                ld_sign = lane[15];
            end
            2'b10: begin
                ld_mask = XLEN'(32'hFFFF_FFFF);
                ld_sign = lane[31];
            end
            default: ;
        endcase
        ld_data = (lane & ld_mask) | ((ld_sign && !op_uns) ? ~ld_mask : '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            op_size       <= '0;
            op_uns        <= 1'b0;
            op_off        <= '0;
            op_wreg       <= 1'b0;
            op_rd         <= '0;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_be        <= '0;
            out_valid     <= 1'b0;
            out_rd        <= '0;
            out_data      <= '0;
            out_write_reg <= 1'b0;
            misalign_err  <= 1'b0;
            timeout_err   <= 1'b0;
        end else begin
            out_valid    <= 1'b0;
            misalign_err <= 1'b0;
            timeout_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (!is_mem) begin
                            out_valid     <= 1'b1;
                            out_rd        <= in_rd;
                            out_data      <= in_result;
                            out_write_reg <= in_write_reg;
                        end else if (misaligned) begin
                            out_valid     <= 1'b1;
                            misalign_err  <= 1'b1;
                            out_rd        <= in_rd;
                            out_data      <= '0;
                            out_write_reg <= 1'b0;
                        end else begin
                            state     <= REQ;
                            cnt       <= '0;
                            mem_req   <= 1'b1;
                            mem_we    <= in_write;
                            mem_addr  <= WORD_ADDR_W'(in_result >> OFS);
                            mem_wdata <= in_wdata << {off, 3'b000};
                            mem_be    <= be_mask << off;
                            op_size   <= in_funct3[1:0];
                            op_uns    <= in_funct3[2];
                            op_off    <= off;
                            op_wreg   <= in_write_reg;
                            op_rd     <= in_rd;
                        end
                    end
                end
                default: begin
                    // An ack on the final counted cycle takes priority over the timeout.
                    if (mem_ack) begin
                        state     <= IDLE;
                        mem_req   <= 1'b0;
                        out_valid <= 1'b1;
                        out_rd    <= op_rd;
                        if (mem_we) begin
                            out_data      <= '0;
                            out_write_reg <= 1'b0;
                        end else begin
                            out_data      <= ld_data;
                            out_write_reg <= op_wreg;
                        end
                    end else if (cnt == 8'(TIMEOUT - 1)) begin
                        state         <= IDLE;
                        mem_req       <= 1'b0;
                        out_valid     <= 1'b1;
                        timeout_err   <= 1'b1;
                        out_rd        <= op_rd;
                        out_data      <= '0;
                        out_write_reg <= 1'b0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_mem_stage.sv
// Bench for lsu_mem_stage: a 32-bit instance (short timeout) and a 64-bit instance checked against a byte-level model.
module tb_lsu_mem_stage;
    localparam int TO32 = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel64 = 1'b0;
    logic        in_valid = 1'b0;
    logic [63:0] in_result = '0;
    logic [63:0] in_wdata = '0;
    logic [2:0]  in_funct3 = '0;
    logic [4:0]  in_rd = '0;
    logic        in_read = 1'b0;
    logic        in_write = 1'b0;
    logic        in_write_reg = 1'b0;
    logic        mem_ack = 1'b0;
    logic [63:0] mem_rdata = '0;

    logic        in_ready32, mem_req32, mem_we32, out_valid32, out_write_reg32, misalign_err32, timeout_err32;
    logic [29:0] mem_addr32;
    logic [31:0] mem_wdata32, out_data32;
    logic [3:0]  mem_be32;
    logic [4:0]  out_rd32;
    logic        in_ready64, mem_req64, mem_we64, out_valid64, out_write_reg64, misalign_err64, timeout_err64;
    logic [60:0] mem_addr64;
    logic [63:0] mem_wdata64, out_data64;
    logic [7:0]  mem_be64;
    logic [4:0]  out_rd64;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    lsu_mem_stage #(.XLEN(32), .TIMEOUT(TO32)) dut32 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid && !sel64), .in_ready(in_ready32),
        .in_result(in_result[31:0]), .in_wdata(in_wdata[31:0]), .in_funct3(in_funct3),
        .in_rd(in_rd), .in_read(in_read), .in_write(in_write), .in_write_reg(in_write_reg),
        .mem_req(mem_req32), .mem_we(mem_we32), .mem_addr(mem_addr32), .mem_wdata(mem_wdata32),
        .mem_be(mem_be32), .mem_ack(mem_ack && !sel64), .mem_rdata(mem_rdata[31:0]),
        .out_valid(out_valid32), .out_rd(out_rd32), .out_data(out_data32),
        .out_write_reg(out_write_reg32), .misalign_err(misalign_err32), .timeout_err(timeout_err32)
    );

    lsu_mem_stage #(.XLEN(64)) dut64 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid && sel64), .in_ready(in_ready64),
        .in_result(in_result), .in_wdata(in_wdata), .in_funct3(in_funct3),
        .in_rd(in_rd), .in_read(in_read), .in_write(in_write), .in_write_reg(in_write_reg),
        .mem_req(mem_req64), .mem_we(mem_we64), .mem_addr(mem_addr64), .mem_wdata(mem_wdata64),
        .mem_be(mem_be64), .mem_ack(mem_ack && sel64), .mem_rdata(mem_rdata),
        .out_valid(out_valid64), .out_rd(out_rd64), .out_data(out_data64),
        .out_write_reg(out_write_reg64), .misalign_err(misalign_err64), .timeout_err(timeout_err64)
    );

    logic        o_ready, o_req, o_we, o_valid, o_wreg, o_mis, o_to;
    logic [63:0] o_addr, o_wdata, o_be, o_data, o_rd;
    assign o_ready = sel64 ? in_ready64 : in_ready32;
    assign o_req   = sel64 ? mem_req64 : mem_req32;
    assign o_we    = sel64 ? mem_we64 : mem_we32;
    assign o_valid = sel64 ? out_valid64 : out_valid32;
    assign o_wreg  = sel64 ? out_write_reg64 : out_write_reg32;
    assign o_mis   = sel64 ? misalign_err64 : misalign_err32;
    assign o_to    = sel64 ? timeout_err64 : timeout_err32;
    assign o_addr  = sel64 ? 64'(mem_addr64) : 64'(mem_addr32);
    assign o_wdata = sel64 ? mem_wdata64 : 64'(mem_wdata32);
    assign o_be    = sel64 ? 64'(mem_be64) : 64'(mem_be32);
    assign o_data  = sel64 ? out_data64 : 64'(out_data32);
    assign o_rd    = sel64 ? 64'(out_rd64) : 64'(out_rd32);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Byte-level reference: which lanes an access touches, where store bytes land, what a load returns.
    function automatic void model(input int xl, input logic [2:0] f3, input logic [63:0] addr,
                                  input logic [63:0] wdata, input logic [63:0] rdata,
                                  output bit mis, output logic [63:0] be, output logic [63:0] wd,
                                  output logic [63:0] ld);
        int nb, bytes, off;
        nb    = xl / 8;
        bytes = 1 << f3[1:0];
        off   = int'(addr[2:0]) % nb;
        mis   = (bytes > nb) || ((int'(addr[2:0]) % bytes) != 0);
        be = '0; wd = '0; ld = '0;
        for (int k = 0; k < nb - off; k++) wd[8*(off+k) +: 8] = wdata[8*k +: 8];
        if (!mis) begin
            for (int i = 0; i < bytes; i++) begin
                be[off+i]     = 1'b1;
                ld[8*i +: 8]  = rdata[8*(off+i) +: 8];
            end
            if (!f3[2] && ld[8*bytes-1])
                for (int b = 8 * bytes; b < xl; b++) ld[b] = 1'b1;
        end
    endfunction

    task automatic run_op(input bit x64, input logic [2:0] f3, input logic [63:0] addr,
                          input logic [63:0] wdata, input logic [63:0] rdata, input logic [4:0] rd,
                          input bit rd_en, input bit wr_en, input bit wreg, input int waits,
                          input bit no_ack);
        int xl; bit mis, mem;
        logic [63:0] xmask, be_e, wd_e, ld_e, rdm;
        xl    = x64 ? 64 : 32;
        xmask = x64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        rdm   = rdata & xmask;
        model(xl, f3, addr & xmask, wdata & xmask, rdm, mis, be_e, wd_e, ld_e);
        mem = rd_en || wr_en;
        @(negedge clk);
        sel64 = x64; in_valid = 1'b1; in_result = addr & xmask; in_wdata = wdata & xmask;
        in_funct3 = f3; in_rd = rd; in_read = rd_en; in_write = wr_en; in_write_reg = wreg;
        chk("in_ready_idle", o_ready, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        if (mem && !mis) begin
            chk("mem_req_start", o_req, 1);
            chk("mem_we", o_we, wr_en);
            chk("mem_addr", o_addr, (addr & xmask) / (xl / 8));
            chk("mem_be", o_be, be_e);
            if (wr_en) chk("mem_wdata", o_wdata, wd_e);
            chk("in_ready_busy", o_ready, 0);
            for (int w = 0; w < waits; w++) begin
                @(negedge clk);
                chk("mem_req_held", o_req, 1);
                if (wr_en) chk("mem_wdata_held", o_wdata, wd_e);
                chk("no_early_valid", o_valid, 0);
            end
            if (!no_ack) begin
                mem_ack = 1'b1; mem_rdata = rdm;
                @(negedge clk);
                mem_ack = 1'b0;
            end else begin
                @(negedge clk);
            end
            chk("mem_req_dropped", o_req, 0);
        end else begin
            chk("no_mem_req", o_req, 0);
        end
        chk("out_valid", o_valid, 1);
        chk("out_rd", o_rd, rd);
        chk("misalign_err", o_mis, mem && mis);
        chk("timeout_err", o_to, mem && !mis && no_ack);
        if (!mem) begin
            chk("out_data_pass", o_data, addr & xmask);
            chk("out_wreg_pass", o_wreg, wreg);
        end else if (mis || no_ack || wr_en) begin
            chk("out_data_zero", o_data, 0);
            chk("out_wreg_zero", o_wreg, 0);
        end else begin
            chk("out_data_load", o_data, ld_e);
            chk("out_wreg_load", o_wreg, wreg);
        end
        @(negedge clk);
        chk("out_valid_pulse", o_valid, 0);
        chk("in_ready_after", o_ready, 1);
    endtask

    initial begin
        #1;
        chk("rst_in_ready", in_ready32, 1);
        chk("rst_mem_req", mem_req32, 0);
        chk("rst_mem_be", mem_be32, 0);
        chk("rst_out_valid", out_valid32, 0);
        chk("rst_out_data", out_data32, 0);
        chk("rst_mem_addr64", mem_addr64, 0);
        chk("rst_out_data64", out_data64, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases: LW, LB/LBU, SH with waits, misaligned LW, timeout, ack on last cycle, LD at 32/64.
        run_op(0, 3'b010, 64'h3C, 64'h0, 64'h0000000F, 5'd15, 1, 0, 1, 0, 0);
        run_op(0, 3'b000, 64'h41, 64'h0, 64'h00008000, 5'd3, 1, 0, 1, 0, 0);
        run_op(0, 3'b100, 64'h41, 64'h0, 64'h00008000, 5'd4, 1, 0, 1, 0, 0);
        run_op(0, 3'b001, 64'h42, 64'h00001234, 64'h0, 5'd5, 0, 1, 1, 3, 0);
        run_op(0, 3'b010, 64'h02, 64'h0, 64'h0, 5'd6, 1, 0, 1, 0, 0);
        run_op(0, 3'b010, 64'h10, 64'h0, 64'h0, 5'd7, 1, 0, 1, TO32 - 1, 1);
        @(negedge clk);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("late_ack_no_valid", out_valid32, 0);
        chk("late_ack_no_req", mem_req32, 0);
        run_op(0, 3'b010, 64'h14, 64'h0, 64'hCAFEF00D, 5'd8, 1, 0, 1, TO32 - 1, 0);
        run_op(0, 3'b011, 64'h08, 64'h0, 64'h0, 5'd9, 1, 0, 1, 0, 0);
        run_op(0, 3'b010, 64'h1235, 64'h0, 64'h0, 5'd10, 0, 0, 1, 0, 0);
        run_op(1, 3'b011, 64'h08, 64'h0, 64'h8123456789ABCDEF, 5'd11, 1, 0, 1, 0, 0);
        run_op(1, 3'b110, 64'h0C, 64'h0, 64'h8123456789ABCDEF, 5'd12, 1, 0, 1, 1, 0);

        // Reset in the middle of an outstanding request.
        @(negedge clk);
        sel64 = 1'b0; in_valid = 1'b1; in_result = 64'h20; in_funct3 = 3'b010;
        in_read = 1'b1; in_write = 1'b0; in_write_reg = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("midreq_req", mem_req32, 1);
        #2 rst = 1'b1;
        #1;
        chk("midreq_async_drop", mem_req32, 0);
        chk("midreq_no_valid", out_valid32, 0);
        @(negedge clk);
        rst = 1'b0;
        chk("midreq_ready", in_ready32, 1);
        @(negedge clk);
        chk("midreq_still_no_valid", out_valid32, 0);

        for (int n = 0; n < 80; n++) begin
            bit x, rde, wre;
            int size, kind;
            logic [63:0] a;
            x    = (n % 2) == 1;
            size = $urandom_range(0, 3);
            kind = $urandom_range(0, 2);
            rde  = (kind == 1);
            wre  = (kind == 2);
            a    = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) a = a & ~64'((1 << size) - 1);
            run_op(x, {1'($urandom_range(0, 1)), 2'(size)}, a, {$urandom, $urandom},
                   {$urandom, $urandom}, 5'($urandom_range(0, 31)), rde, wre,
                   1'($urandom_range(0, 1)), $urandom_range(0, 2), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
